// File: rtl/fibonacci_consumer.sv
// Consumer endpoint of the GALS Fibonacci chain. It pops words from the clock-crossing FIFO,
// holds each one on c_out, and checks it against a locally regenerated Fibonacci sequence.
module fibonacci_consumer #(
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clock_2,
    input  logic              reset,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [DATA_W-1:0] c_out,
    output logic              c_valid,
    output logic [CNT_W-1:0]  count,
    output logic              err,
    output logic [DATA_W-1:0] err_data,
    output logic [CNT_W-1:0]  err_index
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [DATA_W-1:0]   exp_a_r;
    logic [DATA_W-1:0]   exp_b_r;
    logic                rd_req_s;
    logic                capture_s;
    logic                hold_done_s;
    logic                mismatch_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    assign hold_done_s = (hold_cnt_r == {HOLD_W{1'b0}});
    assign mismatch_s  = (fifo_data != exp_a_r);
    // A pop must never escape while reset is held, even before the state register settles.
    assign fifo_rd     = rd_req_s & ~reset;

    // Next-state logic, the pop request and the capture strobe.
    always_comb begin
        state_next_s = state_r;
        rd_req_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ: begin
                if (!fifo_empty) begin
                    rd_req_s     = 1'b1;
                    state_next_s = CAPTURE;
                end else if (!start) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = READ;
                end
            end
            CAPTURE: begin
                // A popped word is always taken, even if start has already dropped.
                capture_s    = 1'b1;
                state_next_s = HOLD;
            end
            HOLD: begin
                if (hold_done_s) begin
                    state_next_s = start ? READ : IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock_2) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Display word, its one-cycle valid pulse and the saturating accepted-word count.
    always_ff @(posedge clock_2) begin
        if (reset) begin
            c_out   <= {DATA_W{1'b0}};
            c_valid <= 1'b0;
            count   <= {CNT_W{1'b0}};
        end else begin
            c_valid <= capture_s;
            if (capture_s) begin
                c_out <= fifo_data;
                count <= sat_inc(count);
            end
        end
    end

    // Hold timer: loaded on capture, counts down to zero while in HOLD.
    always_ff @(posedge clock_2) begin
        if (reset) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else if (capture_s) begin
            hold_cnt_r <= HOLD_LOAD;
        end else if ((state_r == HOLD) && !hold_done_s) begin
            hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
        end
    end

    // Reference sequence; wraps mod 2^DATA_W like the producer and never resyncs to received data.
    always_ff @(posedge clock_2) begin
        if (reset) begin
            exp_a_r <= {DATA_W{1'b0}};
            exp_b_r <= {{(DATA_W-1){1'b0}}, 1'b1};
        end else if (capture_s) begin
            exp_a_r <= exp_b_r;
            exp_b_r <= exp_a_r + exp_b_r;
        end
    end

    // Sticky first-mismatch report; later mismatches leave it untouched.
    always_ff @(posedge clock_2) begin
        if (reset) begin
            err       <= 1'b0;
            err_data  <= {DATA_W{1'b0}};
            err_index <= {CNT_W{1'b0}};
        end else if (capture_s && !err && mismatch_s) begin
            err       <= 1'b1;
            err_data  <= fifo_data;
            err_index <= count;
        end
    end

endmodule

// File: tb/tb_fibonacci_consumer.sv
// Scoreboard bench for fibonacci_consumer: a FIFO model feeds words, and a monitor checks every
// c_valid against queued expectations and an independent Fibonacci/error reference model.
module tb_fibonacci_consumer;

    localparam int DATA_W      = 16;
    localparam int HOLD_CYCLES = 4;
    localparam int CNT_W       = 8;

    logic              clock_2    = 1'b0;
    logic              reset      = 1'b0;
    logic              start      = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_data  = 16'd0;
    logic              fifo_rd;
    logic [DATA_W-1:0] c_out;
    logic              c_valid;
    logic [CNT_W-1:0]  count;
    logic              err;
    logic [DATA_W-1:0] err_data;
    logic [CNT_W-1:0]  err_index;

    fibonacci_consumer #(
        .DATA_W      (DATA_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clock_2    (clock_2),
        .reset      (reset),
        .start      (start),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .c_out      (c_out),
        .c_valid    (c_valid),
        .count      (count),
        .err        (err),
        .err_data   (err_data),
        .err_index  (err_index)
    );

    always #5 clock_2 = ~clock_2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    bit                force_empty = 1'b0;
    int                cyc = 0;

    always @(posedge clock_2) cyc <= cyc + 1;

    // FIFO model: data appears the cycle after a pop; the empty flag settles shortly after each edge.
    always @(posedge clock_2) begin
        if (fifo_rd && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    end

    always @(posedge clock_2) begin
        #2;
        fifo_empty = force_empty || (fifo_q.size() == 0);
    end

    logic [DATA_W-1:0] ma, mb, merr_data, mon_w;
    logic [CNT_W-1:0]  mcnt, merr_idx;
    logic              merr;
    int                cv_seen, rd_seen, last_rd_cyc, last_cv_cyc;
    bit                prev_rd = 1'b0;
    bit                spacing_on = 1'b0;

    // Monitor, sampling on the falling edge.
    always @(negedge clock_2) begin
        if (fifo_rd) begin
            check("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
            check("rd_width", {31'd0, prev_rd}, 32'd0);
            last_rd_cyc = cyc;
            rd_seen++;
        end
        prev_rd = fifo_rd;
        if (c_valid) begin
            check("cv_latency", cyc - last_rd_cyc, 32'd2);
            if (spacing_on && last_cv_cyc >= 0) check("cv_spacing", cyc - last_cv_cyc, HOLD_CYCLES + 2);
            last_cv_cyc = cyc;
            cv_seen++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
                mon_w = c_out;
            end else begin
                mon_w = exp_q.pop_front();
                check("c_out", {16'd0, c_out}, {16'd0, mon_w});
            end
            if (!merr && mon_w != ma) begin
                merr      = 1'b1;
                merr_data = mon_w;
                merr_idx  = mcnt;
            end
            {ma, mb} = {mb, ma + mb};
            if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
            check("count", {24'd0, count}, {24'd0, mcnt});
            check("err", {31'd0, err}, {31'd0, merr});
            check("err_data", {16'd0, err_data}, {16'd0, merr_data});
            check("err_index", {24'd0, err_index}, {24'd0, merr_idx});
        end
    end

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic rst_apply(input bit preload);
        @(posedge clock_2);
        #1;
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        ma = 16'd0; mb = 16'd1; merr = 1'b0; merr_data = 16'd0; merr_idx = 8'd0; mcnt = 8'd0;
        cv_seen = 0; rd_seen = 0; last_cv_cyc = -1; last_rd_cyc = 0;
        if (preload) push_word(16'd0);
        repeat (3) begin
            @(posedge clock_2);
            @(negedge clock_2);
            check("rst_ctl", {29'd0, fifo_rd, c_valid, err}, 32'd0);
            check("rst_cnt", {16'd0, count, err_index}, 32'd0);
            check("rst_data", {c_out, err_data}, 32'd0);
        end
        @(posedge clock_2);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_cv(input int n, input int budget);
        int k = 0;
        while (cv_seen < n && k < budget) begin
            @(negedge clock_2);
            k++;
        end
        check("wait_cv", cv_seen, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int fa, fb, tmp, k;
        int rd0;

        // Reset held with start high and a word waiting; first post-reset cycle is IDLE.
        start = 1'b1;
        rst_apply(1'b1);
        @(negedge clock_2);
        check("idle_after_rst", {31'd0, fifo_rd}, 32'd0);
        @(negedge clock_2);
        check("read_after_idle", {31'd0, fifo_rd}, 32'd1);
        wait_cv(1, 20);

        // Back-to-back words at the minimum period.
        rst_apply(1'b0);
        spacing_on = 1'b1;
        push_word(16'd0); push_word(16'd1); push_word(16'd1);
        push_word(16'd2); push_word(16'd3); push_word(16'd5);
        wait_cv(6, 100);
        spacing_on = 1'b0;
        check("t2_count", {24'd0, count}, 32'd6);
        check("t2_c_out", {16'd0, c_out}, 32'd5);
        check("t2_err", {31'd0, err}, 32'd0);

        // Empty FIFO held for 10 cycles while in READ.
        force_empty = 1'b1;
        rst_apply(1'b0);
        push_word(16'd0);
        @(negedge clock_2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_2);
            check("empty_no_rd", {31'd0, fifo_rd}, 32'd0);
        end
        @(posedge clock_2);
        #1;
        force_empty = 1'b0;
        wait_cv(1, 20);
        check("t3_rd_once", rd_seen, 32'd1);
        check("t3_c_out", {16'd0, c_out}, 32'd0);

        // 26-word true sequence with F25 wrapped mod 2^16.
        rst_apply(1'b0);
        fa = 0; fb = 1;
        for (int i = 0; i < 26; i++) begin
            push_word(fa[15:0]);
            tmp = fa + fb; fa = fb; fb = tmp;
        end
        wait_cv(26, 26 * (HOLD_CYCLES + 2) + 40);
        check("t4_count", {24'd0, count}, 32'd26);
        check("t4_err", {31'd0, err}, 32'd0);
        check("t4_f25_wrap", {16'd0, c_out}, 32'd9489);

        // Corrupted sequence: first mismatch is sticky.
        rst_apply(1'b0);
        push_word(16'd0); push_word(16'd1); push_word(16'd7); push_word(16'd2); push_word(16'd9);
        wait_cv(3, 40);
        check("t5_err3", {31'd0, err}, 32'd1);
        check("t5_data3", {16'd0, err_data}, 32'd7);
        check("t5_idx3", {24'd0, err_index}, 32'd2);
        wait_cv(5, 40);
        check("t5_data5", {16'd0, err_data}, 32'd7);
        check("t5_idx5", {24'd0, err_index}, 32'd2);
        check("t5_count", {24'd0, count}, 32'd5);

        // start dropped during HOLD: HOLD completes, no further pops until start returns.
        rst_apply(1'b0);
        push_word(16'd0); push_word(16'd1);
        wait_cv(1, 20);
        @(posedge clock_2);
        #1;
        start = 1'b0;
        rd0 = rd_seen;
        repeat (20) @(negedge clock_2);
        check("t6_no_rd", rd_seen - rd0, 32'd0);
        check("t6_count", {24'd0, count}, 32'd1);
        @(posedge clock_2);
        #1;
        start = 1'b1;
        wait_cv(2, 20);
        check("t6_resume", {24'd0, count}, 32'd2);

        // Reset asserted during CAPTURE: no c_valid, everything at reset values.
        rst_apply(1'b0);
        push_word(16'd5);
        k = 0;
        while (!fifo_rd && k < 20) begin
            @(negedge clock_2);
            k++;
        end
        check("t6b_rd_seen", {31'd0, fifo_rd}, 32'd1);
        @(posedge clock_2);
        #1;
        reset = 1'b1;
        @(posedge clock_2);
        @(negedge clock_2);
        check("t6b_ctl", {29'd0, fifo_rd, c_valid, err}, 32'd0);
        check("t6b_cnt", {16'd0, count, err_index}, 32'd0);
        check("t6b_data", {c_out, err_data}, 32'd0);
        @(posedge clock_2);
        #1;
        reset = 1'b0;

        // Accepted-word counter saturates at all-ones.
        rst_apply(1'b0);
        for (int i = 0; i < 260; i++) push_word(16'd0);
        wait_cv(260, 260 * (HOLD_CYCLES + 2) + 60);
        check("t7_sat", {24'd0, count}, 32'd255);
        check("t7_err", {31'd0, err}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
